apb_node_timeout: RTL and testbench

APB_NODE_TIMEOUT -- requirements
Module: apb_node_timeout

---
 rtl/apb_node_pkg.sv | 23 ++
 rtl/apb_node_decode.sv | 32 +++
 rtl/apb_node_timeout.sv | 182 ++++++++++++++++++
 tb/tb_apb_node_timeout.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_node_pkg.sv
// Shared types for the APB node: FSM state encoding, address-rule record
// and the read data returned on decode/timeout errors.
package apb_node_pkg;

  // Widest address the rule record can hold; narrower buses zero-extend.
  localparam int unsigned RULE_AW = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR
  } apb_state_e;

  typedef struct packed {
    logic [RULE_AW-1:0] start_addr;
    logic [RULE_AW-1:0] end_addr;
  } addr_rule_t;

  localparam logic [63:0] ERR_RDATA = '0;

endpackage

// File: rtl/apb_node_decode.sv
// Address decoder: inclusive unsigned range match per slave, lowest index
// wins when regions overlap.
module apb_node_decode
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_SLAVE       = 10,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  localparam int unsigned IDX_W         = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1
) (
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  addr_rule_t [NB_SLAVE-1:0] rules_i,
  output logic                      hit_o,
  output logic [IDX_W-1:0]          idx_o
);

  logic [RULE_AW-1:0] addr_ext;

  assign addr_ext = RULE_AW'(addr_i);

  // Priority encode the first matching region.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < NB_SLAVE; k++) begin
      if (!hit_o && addr_ext >= rules_i[k].start_addr && addr_ext <= rules_i[k].end_addr) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/apb_node_timeout.sv
// APB 1-to-N node with registered outputs and optional ACCESS timeout.
// Define APB_NODE_TIMEOUT_EN to enable the timeout counter; without it
// an ACCESS phase waits for the slave indefinitely.
module apb_node_timeout
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_SLAVE       = 10,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [APB_ADDR_WIDTH-1:0]                m_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                m_pwdata_i,
  input  logic                                     m_pwrite_i,
  input  logic                                     m_psel_i,
  input  logic                                     m_penable_i,
  output logic [APB_DATA_WIDTH-1:0]                m_prdata_o,
  output logic                                     m_pready_o,
  output logic                                     m_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]                s_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                s_pwdata_o,
  output logic                                     s_pwrite_o,
  output logic [NB_SLAVE-1:0]                      s_psel_o,
  output logic [NB_SLAVE-1:0]                      s_penable_o,
  input  logic [NB_SLAVE-1:0][APB_DATA_WIDTH-1:0]  s_prdata_i,
  input  logic [NB_SLAVE-1:0]                      s_pready_i,
  input  logic [NB_SLAVE-1:0]                      s_pslverr_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0]  end_addr_i
);

  localparam int unsigned IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  apb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          sel_q, sel_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [NB_SLAVE-1:0]       s_psel_q, s_psel_d;
  logic [NB_SLAVE-1:0]       s_penable_q, s_penable_d;
  logic [APB_DATA_WIDTH-1:0] m_prdata_q, m_prdata_d;
  logic                      m_pready_q, m_pready_d;
  logic                      m_pslverr_q, m_pslverr_d;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  addr_rule_t [NB_SLAVE-1:0] rules;
  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;

  // Repack the per-slave bounds into rule records for the decoder.
  always_comb begin
    for (int unsigned k = 0; k < NB_SLAVE; k++) begin
      rules[k].start_addr = RULE_AW'(start_addr_i[k]);
      rules[k].end_addr   = RULE_AW'(end_addr_i[k]);
    end
  end

  apb_node_decode #(
    .NB_SLAVE       (NB_SLAVE),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_decode (
    .addr_i  (m_paddr_i),
    .rules_i (rules),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx)
  );

  // Next-state and next-output logic; outputs are derived from the next
  // state so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    m_prdata_d  = '0;
    m_pready_d  = 1'b0;
    m_pslverr_d = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m_psel_i && !m_penable_i) begin
          paddr_d  = m_paddr_i;
          pwdata_d = m_pwdata_i;
          pwrite_d = m_pwrite_i;
          if (dec_hit) begin
            sel_d   = dec_idx;
            state_d = ST_SETUP;
          end else begin
            state_d     = ST_ERR;
            m_pready_d  = 1'b1;
            m_pslverr_d = 1'b1;
            m_prdata_d  = APB_DATA_WIDTH'(ERR_RDATA);
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (s_pready_i[sel_q]) begin
          state_d     = ST_RESP;
          m_pready_d  = 1'b1;
          m_pslverr_d = s_pslverr_i[sel_q];
          m_prdata_d  = pwrite_q ? '0 : s_prdata_i[sel_q];
        end
`ifdef APB_NODE_TIMEOUT_EN
        // cnt_q counts completed wait cycles, so this is the last allowed one.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_RESP;
          m_pready_d  = 1'b1;
          m_pslverr_d = 1'b1;
          m_prdata_d  = APB_DATA_WIDTH'(ERR_RDATA);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    s_psel_d    = '0;
    s_penable_d = '0;
    if (state_d == ST_SETUP || state_d == ST_ACCESS) s_psel_d[sel_d] = 1'b1;
    if (state_d == ST_ACCESS) s_penable_d[sel_d] = 1'b1;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      s_psel_q    <= '0;
      s_penable_q <= '0;
      m_prdata_q  <= '0;
      m_pready_q  <= 1'b0;
      m_pslverr_q <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      s_psel_q    <= s_psel_d;
      s_penable_q <= s_penable_d;
      m_prdata_q  <= m_prdata_d;
      m_pready_q  <= m_pready_d;
      m_pslverr_q <= m_pslverr_d;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign m_prdata_o  = m_prdata_q;
  assign m_pready_o  = m_pready_q;
  assign m_pslverr_o = m_pslverr_q;
  assign s_paddr_o   = paddr_q;
  assign s_pwdata_o  = pwdata_q;
  assign s_pwrite_o  = pwrite_q;
  assign s_psel_o    = s_psel_q;
  assign s_penable_o = s_penable_q;

endmodule

// File: tb/tb_apb_node_timeout.sv
// Self-checking bench for apb_node_timeout: master/slave stimulus with a
// range-lookup reference model of the address map and transfer timing.
module tb_apb_node_timeout;

  localparam int NB  = 10;
  localparam int TMO = 8;
`ifdef APB_NODE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          m_paddr_i, m_pwdata_i, m_prdata_o;
  logic                 m_pwrite_i, m_psel_i, m_penable_i, m_pready_o, m_pslverr_o;
  logic [31:0]          s_paddr_o, s_pwdata_o;
  logic                 s_pwrite_o;
  logic [NB-1:0]        s_psel_o, s_penable_o, s_pready_i, s_pslverr_i;
  logic [NB-1:0][31:0]  s_prdata_i, start_addr_i, end_addr_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_data [NB];
  logic        exp_err  [NB];

  apb_node_timeout #(
    .NB_SLAVE       (NB),
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_paddr_i    (m_paddr_i),
    .m_pwdata_i   (m_pwdata_i),
    .m_pwrite_i   (m_pwrite_i),
    .m_psel_i     (m_psel_i),
    .m_penable_i  (m_penable_i),
    .m_prdata_o   (m_prdata_o),
    .m_pready_o   (m_pready_o),
    .m_pslverr_o  (m_pslverr_o),
    .s_paddr_o    (s_paddr_o),
    .s_pwdata_o   (s_pwdata_o),
    .s_pwrite_o   (s_pwrite_o),
    .s_psel_o     (s_psel_o),
    .s_penable_o  (s_penable_o),
    .s_prdata_i   (s_prdata_i),
    .s_pready_i   (s_pready_i),
    .s_pslverr_i  (s_pslverr_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i)
  );

  always #5 clk = ~clk;

  // Reference: lowest-index region containing the address, -1 if none.
  function automatic int exp_slave(input logic [31:0] a);
    for (int k = 0; k < NB; k++)
      if (a >= start_addr_i[k] && a <= end_addr_i[k]) return k;
    return -1;
  endfunction

  function automatic logic [64:0] all_outputs();
    return {m_prdata_o, m_pready_o, m_pslverr_o, s_psel_o, s_penable_o, s_pwrite_o} |
           65'({s_paddr_o, s_pwdata_o} != 64'd0);
  endfunction

  task automatic set_default_map();
    for (int k = 0; k < NB; k++) begin
      start_addr_i[k] = 32'h1A10_0000 + 32'(k) * 32'h1000;
      end_addr_i[k]   = start_addr_i[k] + 32'h0FFF;
    end
  endtask

  task automatic load_slaves();
    for (int k = 0; k < NB; k++) begin
      s_prdata_i[k]  = exp_data[k];
      s_pslverr_i[k] = exp_err[k];
    end
  endtask

  // One master transfer; the slave model raises pready on access cycle wt+1.
  // Observations are sampled at negedges; cyc counts cycles after setup.
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                      input int wt, input int drop_at, input int budget,
                      output int lat, output logic [31:0] rd, output logic er,
                      output int sel, output int n_setup, output int n_access,
                      output int n_multi, output logic [31:0] seen_wdata,
                      output logic [31:0] seen_addr, output logic seen_write);
    int acc;
    lat = -1; rd = '0; er = 1'b0; sel = -1; n_setup = 0; n_access = 0; n_multi = 0;
    seen_wdata = '0; seen_addr = '0; seen_write = 1'b0; acc = 0;
    @(negedge clk);
    m_paddr_i = a; m_pwrite_i = wr; m_pwdata_i = wd; m_psel_i = 1'b1; m_penable_i = 1'b0;
    for (int cyc = 1; cyc <= budget && lat < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) m_penable_i = 1'b1;
      if (cyc == drop_at) begin m_psel_i = 1'b0; m_penable_i = 1'b0; end
      s_pready_i = '0;
      if ($countones(s_psel_o) > 1) n_multi++;
      for (int k = 0; k < NB; k++) begin
        if (s_psel_o[k]) begin
          if (sel < 0) sel = k;
          if (!s_penable_o[k]) begin
            n_setup++; seen_wdata = s_pwdata_o; seen_addr = s_paddr_o; seen_write = s_pwrite_o;
          end else begin
            n_access++; acc++;
            if (acc > wt) s_pready_i[k] = 1'b1;
          end
        end
      end
      if (m_pready_o) begin
        lat = cyc; rd = m_prdata_o; er = m_pslverr_o;
        m_psel_i = 1'b0; m_penable_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (all_outputs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outputs()); else n_pass++;
    n_checks++; if (s_psel_o !== '0) $display("FAIL reset_psel: got %b want 0", s_psel_o); else n_pass++;
  endtask

  task automatic test_read_zero_wait();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    exp_data[1] = 32'hCAFE_0001; exp_err[1] = 1'b0; load_slaves();
    xfer(32'h1A10_1004, 1'b0, '0, 0, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (rd !== 32'hCAFE_0001) $display("FAIL read_data: got %h want cafe0001", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL read_err: got %b want 0", er); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL read_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (sel !== 1) $display("FAIL read_sel: got %0d want 1", sel); else n_pass++;
    n_checks++; if (adv !== 32'h1A10_1004) $display("FAIL read_paddr: got %h want 1a101004", adv); else n_pass++;
  endtask

  task automatic test_write();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    exp_data[3] = 32'hDEAD_BEEF; exp_err[3] = 1'b0; load_slaves();
    xfer(32'h1A10_3000, 1'b1, 32'h55, 1, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (sel !== 3) $display("FAIL write_sel: got %0d want 3", sel); else n_pass++;
    n_checks++; if (nm !== 0) $display("FAIL write_onehot: got %0d multi-select cycles want 0", nm); else n_pass++;
    n_checks++; if (wdv !== 32'h55 || wrv !== 1'b1) $display("FAIL write_bus: got %h/%b want 55/1", wdv, wrv); else n_pass++;
    n_checks++; if (ns !== 1 || na !== 2) $display("FAIL write_phases: got setup %0d access %0d want 1/2", ns, na); else n_pass++;
    n_checks++; if (lat !== 4 || rd !== 32'h0) $display("FAIL write_resp: got lat %0d data %h want 4/0", lat, rd); else n_pass++;
  endtask

  task automatic test_unmapped();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    xfer(32'h2000_0000, 1'b0, '0, 0, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (lat !== 1) $display("FAIL unmapped_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL unmapped_resp: got err %b data %h want 1/0", er, rd); else n_pass++;
    n_checks++; if (sel !== -1) $display("FAIL unmapped_sel: got %0d want -1", sel); else n_pass++;
  endtask

  task automatic test_overlap();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    start_addr_i[0] = 32'h1A10_2000; end_addr_i[0] = 32'h1A10_20FF;
    xfer(32'h1A10_2010, 1'b0, '0, 0, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (sel !== 0) $display("FAIL overlap_low: got %0d want 0", sel); else n_pass++;
    xfer(32'h1A10_2800, 1'b0, '0, 0, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (sel !== 2) $display("FAIL overlap_high: got %0d want 2", sel); else n_pass++;
    set_default_map();
  endtask

  task automatic test_drop();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    xfer(32'h1A10_4010, 1'b0, '0, 2, 2, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (na !== 3 || lat !== 5) $display("FAIL drop_continue: got access %0d lat %0d want 3/5", na, lat); else n_pass++;
    exp_data[6] = 32'h0BAD_F00D; exp_err[6] = 1'b1; load_slaves();
    xfer(32'h1A10_6000, 1'b0, '0, 0, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (lat !== 3 || rd !== 32'h0BAD_F00D || er !== 1'b1)
      $display("FAIL drop_next: got lat %0d data %h err %b want 3/0badf00d/1", lat, rd, er); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    exp_data[5] = 32'h1234_5678; exp_err[5] = 1'b0; load_slaves();
`ifdef APB_NODE_TIMEOUT_EN
    xfer(32'h1A10_5000, 1'b0, '0, 100000, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (na !== TMO || lat !== TMO + 2) $display("FAIL timeout_expire: got access %0d lat %0d want %0d/%0d", na, lat, TMO, TMO + 2); else n_pass++;
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL timeout_resp: got err %b data %h want 1/0", er, rd); else n_pass++;
    xfer(32'h1A10_5000, 1'b0, '0, TMO - 1, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (lat !== TMO + 2 || er !== 1'b0 || rd !== 32'h1234_5678)
      $display("FAIL timeout_ready_wins: got lat %0d err %b data %h want %0d/0/12345678", lat, er, rd, TMO + 2); else n_pass++;
`else
    xfer(32'h1A10_5000, 1'b0, '0, 100000, 0, 1001, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (lat !== -1 || na !== 1000) $display("FAIL no_timeout_wait: got lat %0d access %0d want -1/1000", lat, na); else n_pass++;
    n_checks++; if (s_psel_o !== 10'b00_0010_0000 || s_penable_o !== 10'b00_0010_0000 || m_pready_o !== 1'b0)
      $display("FAIL no_timeout_hold: got psel %b pen %b pready %b want slave 5 held", s_psel_o, s_penable_o, m_pready_o); else n_pass++;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_psel_i = 1'b0; m_penable_i = 1'b0; s_pready_i = '0;
`endif
  endtask

  task automatic test_reset_mid();
    int lat, sel, ns, na, nm; logic [31:0] rd, wdv, adv; logic er, wrv;
    xfer(32'h1A10_7000, 1'b1, 32'hA5A5_A5A5, 100000, 0, 4, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (s_penable_o !== 10'b00_1000_0000) $display("FAIL resetmid_pre: got pen %b want slave 7 access", s_penable_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (all_outputs() !== '0) $display("FAIL resetmid_clear: got %h want 0", all_outputs()); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; m_psel_i = 1'b0; m_penable_i = 1'b0; s_pready_i = '0;
    exp_data[8] = 32'h8888_0008; exp_err[8] = 1'b0; load_slaves();
    xfer(32'h1A10_8ABC, 1'b0, '0, 1, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
    n_checks++; if (lat !== 4 || rd !== 32'h8888_0008 || sel !== 8)
      $display("FAIL resetmid_next: got lat %0d data %h sel %0d want 4/88880008/8", lat, rd, sel); else n_pass++;
  endtask

  task automatic test_random();
    int lat, sel, ns, na, nm, r, wt, k, e_lat; logic [31:0] rd, wdv, adv, a, wd, e_rd; logic er, wrv, e_er; bit wr;
    for (int i = 0; i < NB; i++) begin
      exp_data[i] = $urandom; exp_err[i] = 1'($urandom_range(0, 1));
    end
    load_slaves();
    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, NB);
      a  = (r == NB) ? 32'h3000_0000 + 32'($urandom_range(0, 4095)) : start_addr_i[r] + 32'($urandom_range(0, 4095));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      wt = $urandom_range(0, 3);
      k  = exp_slave(a);
      if (k < 0) begin
        e_lat = 1; e_er = 1'b1; e_rd = '0;
      end else if (TMO_EN && wt >= TMO) begin
        e_lat = 2 + TMO; e_er = 1'b1; e_rd = '0;
      end else begin
        e_lat = 3 + wt; e_er = exp_err[k]; e_rd = wr ? 32'h0 : exp_data[k];
      end
      xfer(a, wr, wd, wt, 0, 50, lat, rd, er, sel, ns, na, nm, wdv, adv, wrv);
      n_checks++;
      if (lat !== e_lat || rd !== e_rd || er !== e_er || sel !== k || nm !== 0)
        $display("FAIL random_%0d: addr %h got lat %0d data %h err %b sel %0d multi %0d want %0d/%h/%b/%0d/0",
                 t, a, lat, rd, er, sel, nm, e_lat, e_rd, e_er, k);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_paddr_i = '0; m_pwdata_i = '0; m_pwrite_i = 1'b0; m_psel_i = 1'b0; m_penable_i = 1'b0;
    s_pready_i = '0;
    for (int i = 0; i < NB; i++) begin exp_data[i] = 32'h5000_0000 + 32'(i); exp_err[i] = 1'b0; end
    load_slaves();
    set_default_map();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_read_zero_wait();
    test_write();
    test_unmapped();
    test_overlap();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
